// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and width helpers.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Emits one tick every PRESCALE enabled cycles; clear restarts the count at 0.
module tick_prescaler
    import pulse_stretcher_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event strobes into fixed-length level pulses separated by
// a fixed low gap, queueing events that arrive while a pulse is in progress.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int  PRESCALE    = 50000,
    parameter int  HIGH_TICKS  = 100,
    parameter int  GAP_TICKS   = 20,
    parameter int  MAX_PENDING = 7,
    localparam int PW          = clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pulse_in,
    output logic          level_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int TW = clog2(max2(HIGH_TICKS, GAP_TICKS) + 1);
    localparam logic [TW-1:0] HIGH_LAST = TW'(HIGH_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [PW-1:0] MAX_P     = PW'(MAX_PENDING);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          pre_clear;
    logic          pre_enable;
    logic          last_tick;
    logic          high_done;
    logic          gap_done;

    // Holding the prescaler clear in IDLE makes every HIGH entry start at 0;
    // the HIGH->GAP and GAP->HIGH hand-offs land on its natural wrap.
    assign pre_clear  = (state == IDLE);
    assign pre_enable = (state != IDLE);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (tick)
    );

    assign last_tick = (state == HIGH) ? (tick_cnt == HIGH_LAST) : (tick_cnt == GAP_LAST);
    assign high_done = (state == HIGH) && tick && last_tick;
    assign gap_done  = (state == GAP)  && tick && last_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;

            if (state != IDLE && tick) begin
                tick_cnt <= last_tick ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (pulse_in) begin
                        state     <= HIGH;
                        level_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HIGH, GAP: begin
                    if (gap_done) begin
                        // A new strobe here either replaces the consumed queued
                        // event or is consumed itself, so pending only drops
                        // when no strobe arrives.
                        if (pending != '0 || pulse_in) begin
                            state     <= HIGH;
                            level_out <= 1'b1;
                            if (!pulse_in) pending <= pending - 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        if (high_done) begin
                            state     <= GAP;
                            level_out <= 1'b0;
                        end
                        if (pulse_in) begin
                            if (pending == MAX_P) overflow <= 1'b1;
                            else                  pending  <= pending + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    level_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Table-driven bench for pulse_stretcher with a scoreboard of accepted events.
`timescale 1ns/1ps
module tb_pulse_stretcher;

    localparam int HI_CYC = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pulse_in = 1'b0;
    logic       level_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .PRESCALE    (4),
        .HIGH_TICKS  (3),
        .GAP_TICKS   (2),
        .MAX_PENDING (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    typedef struct { int scen; int cyc; bit drop; } pulse_t;
    typedef struct { int scen; int cyc; int val; } pend_t;
    typedef struct { int n_cyc; int h0; int h1; int h2; int idle_at; int ovf_cyc; } scen_t;

    pulse_t ptab[$];
    pend_t  qtab[$];
    scen_t  stab[5];
    int     exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     prev_lvl;
    int     rise_c;

    task automatic chk(input string name, input int cyc, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic add_p(input int s, input int c, input bit d);
        pulse_t p;
        p.scen = s; p.cyc = c; p.drop = d;
        ptab.push_back(p);
    endtask

    task automatic add_q(input int s, input int c, input int v);
        pend_t q;
        q.scen = s; q.cyc = c; q.val = v;
        qtab.push_back(q);
    endtask

    task automatic set_s(input int i, input int n, input int a, input int b, input int c,
                         input int idle, input int ovf);
        stab[i].n_cyc = n; stab[i].h0 = a; stab[i].h1 = b; stab[i].h2 = c;
        stab[i].idle_at = idle; stab[i].ovf_cyc = ovf;
    endtask

    function automatic int in_high(input scen_t s, input int c);
        int r;
        r = 0;
        if (s.h0 != 0 && c >= s.h0 && c < s.h0 + HI_CYC) r = 1;
        if (s.h1 != 0 && c >= s.h1 && c < s.h1 + HI_CYC) r = 1;
        if (s.h2 != 0 && c >= s.h2 && c < s.h2 + HI_CYC) r = 1;
        return r;
    endfunction

    task automatic do_reset();
        pulse_in = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rst_level", 0, int'(level_out), 0);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_pending", 0, int'(pending), 0);
        chk("rst_overflow", 0, int'(overflow), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_scenario(input int si, input bit rst);
        scen_t s;
        s = stab[si];
        if (rst) do_reset();
        prev_lvl = 0;
        rise_c   = 0;
        exp_q.delete();
        @(posedge clk);
        for (int c = 1; c <= s.n_cyc; c++) begin
            int ep;
            @(negedge clk);
            ep = 0;
            foreach (qtab[k]) if (qtab[k].scen == si && qtab[k].cyc <= c) ep = qtab[k].val;
            chk($sformatf("s%0d_level", si), c, int'(level_out), in_high(s, c));
            chk($sformatf("s%0d_busy", si), c, int'(busy), int'(c >= s.h0 && c < s.idle_at));
            chk($sformatf("s%0d_pending", si), c, int'(pending), ep);
            chk($sformatf("s%0d_overflow", si), c, int'(overflow), int'(c == s.ovf_cyc));
            if (level_out && prev_lvl == 0) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("s%0d_extra_pulse", si), c, 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk($sformatf("s%0d_pulse_after_event", si), c, int'(c > e), 1);
                end
                rise_c = c;
            end
            if (!level_out && prev_lvl != 0)
                chk($sformatf("s%0d_high_len", si), c, c - rise_c, HI_CYC);
            prev_lvl = int'(level_out);
            pulse_in = 1'b0;
            foreach (ptab[k]) begin
                if (ptab[k].scen == si && ptab[k].cyc == c) begin
                    pulse_in = 1'b1;
                    if (!ptab[k].drop) exp_q.push_back(c);
                end
            end
        end
        pulse_in = 1'b0;
        chk($sformatf("s%0d_sb_drained", si), s.n_cyc, exp_q.size(), 0);
    endtask

    initial begin
        // 0: single, 1: two queued, 2: overflow, 3: strobe on last GAP cycle, 4: held strobe
        set_s(0, 40, 11,  0,  0, 31, -1);
        set_s(1, 60, 11, 31,  0, 51, -1);
        set_s(2, 80, 11, 31, 51, 71, 17);
        set_s(3, 60, 11, 31,  0, 51, -1);
        set_s(4, 80, 11, 31, 51, 71, -1);
        add_p(0, 10, 0);
        add_p(1, 10, 0); add_p(1, 15, 0);
        add_p(2, 10, 0); add_p(2, 12, 0); add_p(2, 14, 0); add_p(2, 16, 1);
        add_p(3, 10, 0); add_p(3, 30, 0);
        add_p(4, 10, 0); add_p(4, 11, 0); add_p(4, 12, 0);
        add_q(1, 16, 1); add_q(1, 31, 0);
        add_q(2, 13, 1); add_q(2, 15, 2); add_q(2, 31, 1); add_q(2, 51, 0);
        add_q(4, 12, 1); add_q(4, 13, 2); add_q(4, 31, 1); add_q(4, 51, 0);

        #3;
        for (int i = 0; i < 5; i++) run_scenario(i, 1'b1);

        // Asynchronous reset in the middle of a HIGH period with one event queued.
        do_reset();
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            pulse_in = (c == 10 || c == 12);
        end
        @(posedge clk);
        #2;
        chk("mid_pre_level", 15, int'(level_out), 1);
        chk("mid_pre_pending", 15, int'(pending), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_level", 15, int'(level_out), 0);
        chk("mid_rst_busy", 15, int'(busy), 0);
        chk("mid_rst_pending", 15, int'(pending), 0);
        chk("mid_rst_overflow", 15, int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        run_scenario(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Inverse of the debouncer: takes single-cycle clean event pulses and turns each one into a fixed-length level pulse.
- A fixed low gap follows every level pulse, so each event is visible on an LED, segment or decimal point in the seven-segment display path.
- Events that arrive while a pulse or gap is still running are queued in a small saturating counter and replayed in order.

Parameters:
PRESCALE, 50000, clk cycles per tick (>=1)
HIGH_TICKS, 100, ticks level_out stays high per event (>=1)
GAP_TICKS, 20, ticks level_out stays low after each high period (>=1)
MAX_PENDING, 7, max queued events (>=1); PW = clog2(MAX_PENDING+1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
pulse_in  input  1  event strobe, synchronous to clk; every high cycle is one event
level_out  output  1  stretched pulse, registered
busy  output  1  high in HIGH or GAP state, registered
pending  output  PW  number of queued events, registered
overflow  output  1  one-cycle strobe when an event is dropped, registered

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; level_out=0, busy=0, pending=0, overflow=0
  - prescaler and tick counter = 0
  - reset mid-pulse aborts immediately; queued events are discarded.
- States: IDLE, HIGH, GAP.
- IDLE:
  - pulse_in=1 moves to HIGH on the next edge.
  - level_out=1 and busy=1 from cycle n+1, where n is the pulse_in cycle.
  - Latency is 1 clk.
- Timing counters:
  - Prescaler counts 0..PRESCALE-1 and is active only in HIGH/GAP.
  - It restarts at 0 on every state entry, so HIGH lasts exactly HIGH_TICKS*PRESCALE clk cycles and GAP lasts exactly GAP_TICKS*PRESCALE clk cycles.
  - Tick counter width is clog2(max(HIGH_TICKS,GAP_TICKS)+1).
- HIGH:
  - level_out=1.
  - After the last cycle of the last tick, go to GAP (level_out=0, busy=1).
- GAP:
  - level_out=0.
  - After the last cycle of the last tick:
    - if pending>0 or pulse_in=1 that cycle, go to HIGH and consume one event;
    - otherwise go to IDLE (busy=0).
- Queueing while busy:
  - pulse_in=1 in HIGH or GAP increments pending.
  - At pending=MAX_PENDING the event is dropped, pending holds and overflow=1 for one cycle.
- Simultaneous events at the GAP->HIGH transition:
  - pulse_in=1 with pending>0: the new event is queued and one is consumed, so pending is unchanged.
  - pulse_in=1 with pending=0: the new event is consumed directly, so pending stays 0.
- Arithmetic:
  - pending never wraps; it saturates at both MAX_PENDING and 0.
  - overflow never asserts in IDLE.
- A multi-cycle pulse_in high counts as one event per high cycle; upstream logic must deliver single-cycle strobes.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, HIGH=2'd1, GAP=2'd2;
  - a clog2 function for deriving widths.
- One natural sub-module: tick_prescaler, with inputs clk, reset, clear, enable and output tick.
  - It generates one tick every PRESCALE enabled cycles and restarts on clear.
  - The same component can replace the free-running divider in slow_clock.
- FSM, tick counter and pending counter stay in pulse_stretcher.

Test Plan:
Bench parameters for all scenarios: PRESCALE=4, HIGH_TICKS=3, GAP_TICKS=2, MAX_PENDING=2 (HIGH=12 clk, GAP=8 clk).
1. Single pulse_in at cycle 10 -> level_out high cycles 11-22, low 23-30 with busy=1, busy=0 from cycle 31, pending=0 throughout.
2. Pulses at cycles 10 and 15 -> pending=1 at cycle 16; second high period cycles 31-42; pending=0 from cycle 31; IDLE at cycle 51.
3. Pulses at cycles 10, 12, 14, 16 -> pending=1 then 2, then overflow=1 exactly at cycle 17 with pending held at 2; three high periods total, no fourth.
4. pulse_in exactly on the last GAP cycle (cycle 30) with pending=0 -> back-to-back HIGH at cycle 31, pending stays 0, no IDLE cycle between.
5. reset asserted asynchronously mid-HIGH (cycle 15, between edges) with pending=1 -> level_out, busy and pending drop to 0 immediately. After release, a new pulse gives the full 12-cycle high period.
6. Held pulse_in high for 3 cycles from IDLE -> first cycle starts HIGH, next two queue (pending=2); three separate high periods observed.
